// File: rtl/fifo_tree_node.sv
// fifo_tree_node: 2:1 round-robin merge of two child FIFOs into one parent.
// Three-state pop/fetch/write loop, one word in flight at a time.
module fifo_tree_node #(
    parameter int DATA_WIDTH = 36
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_a_i,
    input  logic                  empty_a_i,
    output logic                  rden_a_o,
    input  logic [DATA_WIDTH-1:0] data_b_i,
    input  logic                  empty_b_i,
    output logic                  rden_b_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  wren_o,
    input  logic                  full_i,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WRITE
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  rr_ptr;
    logic                  src;
    logic                  gnt_a;
    logic                  gnt_b;
    logic                  can_grant;
    logic [DATA_WIDTH-1:0] out_reg;

    // Next state, pops and parent strobe; all held low while in reset.
    // empty_*_i is high when the child has data.
    always_comb begin
        state_nxt = state;
        rden_a_o  = 1'b0;
        rden_b_o  = 1'b0;
        wren_o    = 1'b0;
        busy_o    = 1'b0;
        can_grant = 1'b0;
        gnt_a     = empty_a_i & (~empty_b_i | ~rr_ptr);
        gnt_b     = empty_b_i & (~empty_a_i | rr_ptr);
        if (!reset) begin
            busy_o = (state != IDLE);
            unique case (state)
                IDLE: begin
                    can_grant = 1'b1;
                end
                FETCH: begin
                    state_nxt = WRITE;
                end
                WRITE: begin
                    if (!full_i) begin
                        wren_o    = 1'b1;
                        can_grant = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
            if (can_grant && (gnt_a || gnt_b)) begin
                rden_a_o  = gnt_a;
                rden_b_o  = gnt_b;
                state_nxt = FETCH;
            end
        end
    end

    // State, arbitration pointer and the output word register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rr_ptr  <= 1'b0;
            src     <= 1'b0;
            out_reg <= '0;
        end else begin
            state <= state_nxt;
            if (rden_a_o || rden_b_o) begin
                rr_ptr <= ~rden_b_o;
                src    <= rden_b_o;
            end
            if (state == FETCH) begin
                out_reg <= src ? data_b_i : data_a_i;
            end
        end
    end

    assign data_o = out_reg;

endmodule

// File: tb/tb_fifo_tree_node.sv
// tb_fifo_tree_node: directed scoreboard bench for the 2:1 merge node.
// Children are modelled as registered-read FIFOs; a negedge monitor checks.
module tb_fifo_tree_node;

    localparam int DW = 36;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] data_a;
    logic [DW-1:0] data_b;
    logic          ne_a;
    logic          ne_b;
    logic          rden_a;
    logic          rden_b;
    logic [DW-1:0] data_o;
    logic          wren_o;
    logic          full_i = 1'b0;
    logic          busy_o;

    logic [DW-1:0] mem_a [128];
    logic [DW-1:0] mem_b [128];
    int            wr_a = 0;
    int            wr_b = 0;
    int            rd_a = 0;
    int            rd_b = 0;
    logic          rden_a_s = 1'b0;
    logic          rden_b_s = 1'b0;

    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] exp_a [$];
    logic [DW-1:0] exp_b [$];
    int            rq [$];

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   mode = 1'b0;
    bit   chk_idle = 1'b0;
    bit   chk_stall = 1'b0;
    bit   chk_lat = 1'b0;
    bit   chk_drain = 1'b0;

    fifo_tree_node #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_a_i  (data_a),
        .empty_a_i (ne_a),
        .rden_a_o  (rden_a),
        .data_b_i  (data_b),
        .empty_b_i (ne_b),
        .rden_b_o  (rden_b),
        .data_o    (data_o),
        .wren_o    (wren_o),
        .full_i    (full_i),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    assign ne_a = (wr_a != rd_a);
    assign ne_b = (wr_b != rd_b);

    // Child FIFOs: registered read data one cycle after the pop.
    always @(posedge clk) begin
        if (rden_a_s) begin
            data_a <= mem_a[rd_a];
            rd_a   <= rd_a + 1;
        end
        if (rden_b_s) begin
            data_b <= mem_b[rd_b];
            rd_b   <= rd_b + 1;
        end
    end

    task automatic check(input string nm, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Monitor: protocol invariants, directed windows and scoreboard.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        cyc++;
        rden_a_s <= rden_a;
        rden_b_s <= rden_b;
        if (rden_a || rden_b) begin
            check("one_rden", {35'd0, rden_a & rden_b}, '0);
        end
        if (rden_a) check("rden_a_nonempty", {35'd0, ne_a}, 36'd1);
        if (rden_b) check("rden_b_nonempty", {35'd0, ne_b}, 36'd1);
        if (wren_o) check("wren_not_full", {35'd0, full_i}, '0);
        if (chk_idle) begin
            check("idle_rden_a", {35'd0, rden_a}, '0);
            check("idle_rden_b", {35'd0, rden_b}, '0);
            check("idle_wren", {35'd0, wren_o}, '0);
            check("idle_busy", {35'd0, busy_o}, '0);
            check("idle_data", data_o, '0);
        end
        if (chk_stall) begin
            check("stall_wren", {35'd0, wren_o}, '0);
            check("stall_rden", {34'd0, rden_a, rden_b}, '0);
            check("stall_data", data_o, 36'h55);
            check("stall_busy", {35'd0, busy_o}, 36'd1);
        end
        if (wren_o) begin
            if (mode == 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_wren", data_o, 'x);
                end else begin
                    e = exp_q.pop_front();
                    check("parent_word", data_o, e);
                end
            end else if (data_o[DW-1]) begin
                if (exp_b.size() == 0) begin
                    check("unexpected_b", data_o, 'x);
                end else begin
                    e = exp_b.pop_front();
                    check("order_b", data_o, e);
                end
            end else begin
                if (exp_a.size() == 0) begin
                    check("unexpected_a", data_o, 'x);
                end else begin
                    e = exp_a.pop_front();
                    check("order_a", data_o, e);
                end
            end
            if (rq.size() != 0) begin
                if (chk_lat) begin
                    check("rden_to_wren", 36'(cyc - rq[0]), 36'd2);
                end
                void'(rq.pop_front());
            end
        end
        if (rden_a || rden_b) rq.push_back(cyc);
        if (reset) rq.delete();
        if (chk_drain) begin
            check("drained",
                  36'(exp_q.size() + exp_a.size() + exp_b.size()), '0);
        end
    end

    task automatic push_a(input logic [DW-1:0] v, input bit ex);
        mem_a[wr_a] = v;
        wr_a++;
        if (ex) begin
            if (mode) exp_a.push_back(v);
            else exp_q.push_back(v);
        end
    endtask

    task automatic push_b(input logic [DW-1:0] v, input bit ex);
        mem_b[wr_b] = v;
        wr_b++;
        if (ex) begin
            if (mode) exp_b.push_back(v);
            else exp_q.push_back(v);
        end
    endtask

    task automatic wait_drain(input int budget);
        int b;
        b = budget;
        while ((exp_q.size() + exp_a.size() + exp_b.size()) > 0 && b > 0) begin
            @(posedge clk);
            #1;
            b--;
        end
        repeat (2) @(posedge clk);
        #1;
        chk_drain = 1'b1;
        @(posedge clk);
        #1;
        chk_drain = 1'b0;
    endtask

    initial begin
        int na;
        int nb;
        // Reset with both children holding data; A/B alternate after.
        for (int i = 0; i < 4; i++) begin
            mem_a[wr_a] = 36'hA0 + 36'(i);
            wr_a++;
            mem_b[wr_b] = 36'hB0 + 36'(i);
            wr_b++;
            exp_q.push_back(36'hA0 + 36'(i));
            exp_q.push_back(36'hB0 + 36'(i));
        end
        @(posedge clk);
        #1;
        chk_idle = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_idle = 1'b0;
        reset = 1'b0;
        wait_drain(40);

        // Only A has data: 2-cycle pop-to-write latency.
        chk_lat = 1'b1;
        push_a(36'h1, 1'b1);
        push_a(36'h2, 1'b1);
        push_a(36'h3, 1'b1);
        wait_drain(20);
        chk_lat = 1'b0;

        // Parent full while holding 0x55.
        full_i = 1'b1;
        push_a(36'h55, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_stall = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk_stall = 1'b0;
        full_i = 1'b0;
        wait_drain(10);

        // Reset during FETCH drops the word, then A is preferred again.
        push_a(36'h77, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_idle = 1'b1;
        @(posedge clk);
        #1;
        chk_idle = 1'b0;
        push_b(36'hC1, 1'b0);
        push_a(36'hC0, 1'b1);
        exp_q.push_back(36'hC1);
        wait_drain(20);

        // Random arrivals with a randomly stalling parent.
        mode = 1'b1;
        na = 0;
        nb = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            full_i = ($urandom_range(0, 2) == 0);
            if (na < 32 && $urandom_range(0, 1) == 1) begin
                push_a({4'h0, 32'($urandom())}, 1'b1);
                na++;
            end
            if (nb < 32 && $urandom_range(0, 1) == 1) begin
                push_b({4'h8, 32'($urandom())}, 1'b1);
                nb++;
            end
            if (na == 32 && nb == 32 &&
                exp_a.size() == 0 && exp_b.size() == 0) break;
        end
        full_i = 1'b0;
        wait_drain(50);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
